// File: rtl/pulse_stretcher.sv
// pulse_stretcher
//
// Turns single-cycle events into fixed-length pulses that are long enough to
// drive LEDs, buzzers or off-chip strobes. Each accepted event yields one
// active pulse of ON_CYCLES followed by at least OFF_CYCLES inactive cycles.
// Events that arrive while a pulse (or its gap) is in progress are queued up
// to MAX_PENDING; beyond that they are dropped and flagged.
//
// Ports:
//   clk       sole clock, rising edge
//   rst       asynchronous, active-high reset
//   trigger   event strobe; every cycle sampled high is one event
//   out       stretched pulse, ACTIVE_LEVEL while a pulse is active (registered)
//   busy      high while a pulse or its trailing gap is in progress (registered)
//   pending   number of queued events (registered)
//   overflow  one-cycle strobe when an event is dropped (registered)

module pulse_stretcher #(
    parameter int unsigned ON_CYCLES    = 1000,
    parameter int unsigned OFF_CYCLES   = 1000,
    parameter int unsigned MAX_PENDING  = 3,
    parameter bit          ACTIVE_LEVEL = 1'b1,
    localparam int unsigned PendW       = (MAX_PENDING > 0) ? $clog2(MAX_PENDING + 1) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger,
    output logic             out,
    output logic             busy,
    output logic [PendW-1:0] pending,
    output logic             overflow
);

    localparam int unsigned MaxCyc = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned TimerW = $clog2(MaxCyc + 1);

    localparam logic [TimerW-1:0] OnLoad  = TimerW'(ON_CYCLES - 1);
    localparam logic [TimerW-1:0] OffLoad = TimerW'((OFF_CYCLES > 0) ? OFF_CYCLES - 1 : 0);
    localparam logic [PendW-1:0]  PendMax = PendW'(MAX_PENDING);

    typedef enum logic [1:0] {StIdle, StOn, StGap} state_e;

    state_e            state_q;
    logic [TimerW-1:0] timer_q;

    logic at_end;     // last cycle of the current ON or GAP phase
    logic decide;     // start decision is taken this cycle
    logic take;       // a queued event is consumed by the start decision
    logic restart;    // a new pulse starts right after this cycle
    logic queue_evt;  // trigger must be queued (or dropped) rather than started

    always_comb begin
        at_end    = (timer_q == '0);
        decide    = at_end && ((state_q == StGap) || ((state_q == StOn) && (OFF_CYCLES == 0)));
        take      = decide && (pending != '0);
        restart   = decide && ((pending != '0) || trigger);
        // With an empty queue a trigger at the decision point starts the next
        // pulse directly; otherwise a busy-time trigger joins the queue.
        queue_evt = trigger && (state_q != StIdle) && !(decide && (pending == '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            timer_q  <= '0;
            out      <= ~ACTIVE_LEVEL;
            busy     <= 1'b0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= 1'b0;

            // Queue bookkeeping. A queued event consumed in the same cycle a new
            // one arrives leaves the count unchanged, even when full.
            if (queue_evt && take) begin
                pending <= pending;
            end else if (take) begin
                pending <= pending - PendW'(1);
            end else if (queue_evt) begin
                if (pending < PendMax) begin
                    pending <= pending + PendW'(1);
                end else begin
                    overflow <= 1'b1;
                end
            end

            case (state_q)
                StIdle: begin
                    if (trigger) begin
                        state_q <= StOn;
                        timer_q <= OnLoad;
                        out     <= ACTIVE_LEVEL;
                        busy    <= 1'b1;
                    end
                end
                StOn: begin
                    if (!at_end) begin
                        timer_q <= timer_q - TimerW'(1);
                    end else if (OFF_CYCLES != 0) begin
                        state_q <= StGap;
                        timer_q <= OffLoad;
                        out     <= ~ACTIVE_LEVEL;
                    end else if (restart) begin
                        // Zero gap: output stays active across back-to-back pulses.
                        timer_q <= OnLoad;
                    end else begin
                        state_q <= StIdle;
                        out     <= ~ACTIVE_LEVEL;
                        busy    <= 1'b0;
                    end
                end
                StGap: begin
                    if (!at_end) begin
                        timer_q <= timer_q - TimerW'(1);
                    end else if (restart) begin
                        state_q <= StOn;
                        timer_q <= OnLoad;
                        out     <= ACTIVE_LEVEL;
                    end else begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    timer_q <= '0;
                    out     <= ~ACTIVE_LEVEL;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher. Three instances cover the main
// configuration (ON=4, OFF=2, MAX_PENDING=2), the zero-gap case and the
// inverted-polarity case. Cycle numbers count rising edges after reset release.

module tb_pulse_stretcher;

    logic clk;
    logic rst;
    logic trig_a, trig_b, trig_c;

    logic       out_a, busy_a, ovf_a;
    logic [1:0] pend_a;
    logic       out_b, busy_b, ovf_b;
    logic [0:0] pend_b;
    logic       out_c, busy_c, ovf_c;
    logic [1:0] pend_c;

    int checks;
    int errors;
    int cyc;

    pulse_stretcher #(
        .ON_CYCLES   (4),
        .OFF_CYCLES  (2),
        .MAX_PENDING (2),
        .ACTIVE_LEVEL(1'b1)
    ) u_a (
        .clk     (clk),
        .rst     (rst),
        .trigger (trig_a),
        .out     (out_a),
        .busy    (busy_a),
        .pending (pend_a),
        .overflow(ovf_a)
    );

    pulse_stretcher #(
        .ON_CYCLES   (3),
        .OFF_CYCLES  (0),
        .MAX_PENDING (1),
        .ACTIVE_LEVEL(1'b1)
    ) u_b (
        .clk     (clk),
        .rst     (rst),
        .trigger (trig_b),
        .out     (out_b),
        .busy    (busy_b),
        .pending (pend_b),
        .overflow(ovf_b)
    );

    pulse_stretcher #(
        .ON_CYCLES   (2),
        .OFF_CYCLES  (1),
        .MAX_PENDING (3),
        .ACTIVE_LEVEL(1'b0)
    ) u_c (
        .clk     (clk),
        .rst     (rst),
        .trigger (trig_c),
        .out     (out_c),
        .busy    (busy_c),
        .pending (pend_c),
        .overflow(ovf_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       trig;
        logic       out;
        logic       busy;
        logic [1:0] pend;
        logic       ovf;
    } vec_t;

    vec_t vq[30];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reset all instances, check reset values while rst is held, and leave the
    // bench 1 time unit into cycle 0.
    task automatic do_reset();
        trig_a = 1'b0;
        trig_b = 1'b0;
        trig_c = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_out_a", out_a, 1'b0);
        chk("rst_busy_a", busy_a, 1'b0);
        chk("rst_pend_a", pend_a, 2'd0);
        chk("rst_ovf_a", ovf_a, 1'b0);
        chk("rst_out_b", out_b, 1'b0);
        chk("rst_out_c", out_c, 1'b1);
        chk("rst_busy_c", busy_c, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst    = 1'b1;
        trig_a = 1'b0;
        trig_b = 1'b0;
        trig_c = 1'b0;

        // Queueing table: triggers in 10, 12, 13, 14 with MAX_PENDING=2.
        for (int i = 0; i < 30; i++) vq[i] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
        vq[10] = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
        vq[11] = '{1'b0, 1'b1, 1'b1, 2'd0, 1'b0};
        vq[12] = '{1'b1, 1'b1, 1'b1, 2'd0, 1'b0};
        vq[13] = '{1'b1, 1'b1, 1'b1, 2'd1, 1'b0};
        vq[14] = '{1'b1, 1'b1, 1'b1, 2'd2, 1'b0};
        vq[15] = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b1};
        vq[16] = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b0};
        for (int i = 17; i <= 20; i++) vq[i] = '{1'b0, 1'b1, 1'b1, 2'd1, 1'b0};
        vq[21] = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b0};
        vq[22] = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b0};
        for (int i = 23; i <= 26; i++) vq[i] = '{1'b0, 1'b1, 1'b1, 2'd0, 1'b0};
        vq[27] = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b0};
        vq[28] = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b0};

        do_reset();
        for (int c = 0; c < 30; c++) begin
            trig_a = vq[c].trig;
            @(negedge clk);
            chk("q_out", out_a, vq[c].out);
            chk("q_busy", busy_a, vq[c].busy);
            chk("q_pend", pend_a, vq[c].pend);
            chk("q_ovf", ovf_a, vq[c].ovf);
            tick();
        end

        // Single event.
        do_reset();
        for (int c = 0; c < 21; c++) begin
            trig_a = (c == 10);
            @(negedge clk);
            chk("se_out", out_a, (c >= 11 && c <= 14));
            chk("se_busy", busy_a, (c >= 11 && c <= 16));
            chk("se_pend", pend_a, 2'd0);
            tick();
        end

        // Seamless restart from the last gap cycle.
        do_reset();
        for (int c = 0; c < 25; c++) begin
            trig_a = (c == 10) || (c == 16);
            @(negedge clk);
            chk("sr_out", out_a, (c >= 11 && c <= 14) || (c >= 17 && c <= 20));
            chk("sr_busy", busy_a, (c >= 11 && c <= 22));
            chk("sr_pend", pend_a, 2'd0);
            chk("sr_ovf", ovf_a, 1'b0);
            tick();
        end

        // Asynchronous reset mid-pulse with two queued events.
        do_reset();
        for (int c = 0; c < 12; c++) begin
            trig_a = (c >= 9);
            tick();
        end
        trig_a = 1'b0;
        chk("ar_pend_before", pend_a, 2'd2);
        chk("ar_out_before", out_a, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_out", out_a, 1'b0);
        chk("ar_busy", busy_a, 1'b0);
        chk("ar_pend", pend_a, 2'd0);
        chk("ar_ovf", ovf_a, 1'b0);
        while (cyc < 15) tick();
        rst = 1'b0;
        while (cyc < 28) begin
            trig_a = (cyc == 20);
            @(negedge clk);
            chk("ar_post_out", out_a, (cyc >= 21 && cyc <= 24));
            chk("ar_post_busy", busy_a, (cyc >= 21 && cyc <= 26));
            chk("ar_post_pend", pend_a, 2'd0);
            tick();
        end

        // Zero gap (instance b) and inverted polarity (instance c).
        do_reset();
        for (int c = 0; c < 15; c++) begin
            trig_b = (c == 5) || (c == 6);
            trig_c = (c == 3);
            @(negedge clk);
            chk("zg_out", out_b, (c >= 6 && c <= 11));
            chk("zg_busy", busy_b, (c >= 6 && c <= 11));
            chk("zg_pend", pend_b, (c == 7) || (c == 8));
            chk("zg_ovf", ovf_b, 1'b0);
            chk("pol_out", out_c, !(c == 4 || c == 5));
            chk("pol_busy", busy_c, (c >= 4 && c <= 6));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
